alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one `alu` instance between `NUM_REQ` requesters, for example the integer issue path and a branch-compare or address-generation unit. Each requester gets a round-robin valid/ready request channel. The block registers the winning operands and drives them into the shared ALU for one cycle. It captures the result and zero flag, then returns them on a single response channel tagged with the requester index. Only one operation is in flight at a time.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, legal range 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester index.

Ports:
- `i_clk`  in  1  clock; all state updates on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_reqValid`  in  NUM_REQ  per-requester request valid.
- `i_reqA`  in  NUM_REQ×32 (packed `[NUM_REQ-1:0][31:0]`)  operand A per requester.
- `i_reqB`  in  NUM_REQ×32  operand B per requester.
- `i_reqOp`  in  NUM_REQ×4  ALU operation per requester, `pa_riscv` encoding.
- `o_reqReady`  out  NUM_REQ  per-requester accept; at most one bit set.
- `o_aluA`  out  32  operand A to the shared ALU.
- `o_aluB`  out  32  operand B to the shared ALU.
- `o_aluOp`  out  4  `i_aluLogicOperation` to the shared ALU.
- `i_aluResult`  in  32  `o_result` from the shared ALU.
- `i_aluZero`  in  1  `o_zeroFlag` from the shared ALU.
- `o_rspValid`  out  1  response valid.
- `i_rspReady`  in  1  response accept.
- `o_rspResult`  out  32  captured result.
- `o_rspZero`  out  1  captured zero flag.
- `o_rspId`  out  ID_W  index of the requester that issued the operation.

## Operation
- State machine states: IDLE, EXEC, RESP.
  - IDLE → EXEC on a request handshake: `i_reqValid[g] & o_reqReady[g]`.
  - EXEC → RESP unconditionally after one cycle.
  - RESP → IDLE on `o_rspValid & i_rspReady`; otherwise stay in RESP.
- Grant is combinational in IDLE only:
  - Search starts at `(lastGrant+1) mod NUM_REQ`.
  - The first requester with `i_reqValid` set wins, and `o_reqReady[g]` is asserted for that requester only.
  - `o_reqReady` is all-zero in EXEC and RESP.
- On handshake:
  - `i_reqA[g]`, `i_reqB[g]` and `i_reqOp[g]` are registered into the operand registers.
  - `g` is registered into both `o_rspId` and `lastGrant`.
- `o_aluA`, `o_aluB` and `o_aluOp` are driven directly from the operand registers. They stay stable from EXEC through the next handshake.
- At the end of EXEC, `i_aluResult` and `i_aluZero` are captured into `o_rspResult` and `o_rspZero`. The block does not interpret the opcode; unsupported ops return whatever the ALU produces.
- Response registers hold until the next EXEC capture. `o_rspValid` is asserted only in RESP.
- Requesters must hold valid and operands stable until ready. A requester that deasserts valid before ready is simply not granted, and no error is raised.
- Round-robin fairness: with all requesters continuously valid, grants follow 0,1,…,NUM_REQ-1,0,…

## Timing
- Reset values (asynchronous, immediate on `i_rst_n` low):
  - State = IDLE, `lastGrant` = NUM_REQ-1, so requester 0 has first priority.
  - Operand registers = 0, so `o_aluA` = `o_aluB` = 0 and `o_aluOp` = 4'b0.
  - `o_rspValid` = 0, `o_rspResult` = 0, `o_rspZero` = 0, `o_rspId` = 0.
- Latency for a handshake in cycle N:
  - The ALU sees the new operands in cycle N+1 (EXEC).
  - `o_rspValid` rises in cycle N+2.
- Back-pressure: with `i_rspReady` held high, the response handshake completes in N+2 and IDLE is re-entered in N+3. Peak throughput is therefore one operation per 3 cycles.
- A requester valid in the same cycle as the response handshake is not granted until the following (IDLE) cycle; there is no bypass.
- Reset asserted mid-operation (EXEC or RESP):
  - The in-flight operation is discarded.
  - The response is never presented.
  - Priority returns to requester 0.

## Test plan
- Single request, 1 clock after reset release: req0 valid, `a=5`, `b=7`, op=ADD, `i_rspReady`=1 → ready0 in cycle 0, `o_aluA`=5 and `o_aluB`=7 in cycle 1, `o_rspValid` in cycle 2 with result 12, zero 0, id 0.
- Contention: req0 and req1 both valid continuously with distinct operands → grants alternate 0,1,0,1, and ids match the operand sets returned (e.g. SUB 9-9 → result 0, zero 1).
- Back-pressure: hold `i_rspReady`=0 for 5 cycles in RESP → `o_rspValid`, result and id stay stable, all `o_reqReady` stay 0, the ALU inputs are unchanged, and the next grant occurs in the cycle after the response handshake.
- SLT and logic ops via req1 alone: SLT `a=-1`, `b=1` → result 1; AND `0xF0F0`&`0x0FF0` → `0x00F0`; XOR equal operands → result 0, zero 1.
- Reset mid-EXEC with req1 granted → `o_rspValid` never rises for that operation; after release, simultaneous req0 and req1 → req0 is granted first.
- `NUM_REQ`=4, all valid for 8 operations → grant order 0,1,2,3,0,1,2,3, and `o_reqReady` is one-hot or zero every cycle.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin front end that time-shares one ALU between NUM_REQ requesters.
// One operation is in flight at a time; the response is tagged with the requester index.
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_REQ-1:0]       i_reqValid,
    input  logic [NUM_REQ-1:0][31:0] i_reqA,
    input  logic [NUM_REQ-1:0][31:0] i_reqB,
    input  logic [NUM_REQ-1:0][3:0]  i_reqOp,
    output logic [NUM_REQ-1:0]       o_reqReady,
    output logic [31:0]              o_aluA,
    output logic [31:0]              o_aluB,
    output logic [3:0]               o_aluOp,
    input  logic [31:0]              i_aluResult,
    input  logic                     i_aluZero,
    output logic                     o_rspValid,
    input  logic                     i_rspReady,
    output logic [31:0]              o_rspResult,
    output logic                     o_rspZero,
    output logic [ID_W-1:0]          o_rspId
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [31:0]     opa_q, opa_d;
    logic [31:0]     opb_q, opb_d;
    logic [3:0]      op_q, op_d;
    logic [31:0]     result_q, result_d;
    logic            zero_q, zero_d;

    logic [2*NUM_REQ-1:0] valid_dbl;
    logic [NUM_REQ-1:0]   valid_rot;
    logic [ID_W:0]        rot_shift;
    logic [ID_W:0]        rr_sum;
    logic [ID_W-1:0]      grant_off;
    logic [ID_W-1:0]      grant_idx;
    logic                 grant_valid;
    logic                 in_idle;

    // Rotate the valid vector so bit 0 is the requester just after the last winner.
    assign valid_dbl = {i_reqValid, i_reqValid};
    assign rot_shift = {1'b0, last_grant_q} + (ID_W+1)'(1);
    assign valid_rot = NUM_REQ'(valid_dbl >> rot_shift);

    always_comb begin
        grant_valid = 1'b0;
        grant_off   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (valid_rot[j]) begin
                grant_valid = 1'b1;
                grant_off   = ID_W'(j);
            end
        end
    end

    assign rr_sum    = {1'b0, last_grant_q} + (ID_W+1)'(1) + {1'b0, grant_off};
    assign grant_idx = (rr_sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(rr_sum - (ID_W+1)'(NUM_REQ))
                                                      : ID_W'(rr_sum);
    assign in_idle   = (state_q == IDLE);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign o_reqReady[gi] = in_idle & grant_valid & (grant_idx == ID_W'(gi));
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        op_d         = op_q;
        result_d     = result_q;
        zero_d       = zero_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d      = EXEC;
                    opa_d        = i_reqA[grant_idx];
                    opb_d        = i_reqB[grant_idx];
                    op_d         = i_reqOp[grant_idx];
                    rsp_id_d     = grant_idx;
                    last_grant_d = grant_idx;
                end
            end
            EXEC: begin
                state_d  = RESP;
                result_d = i_aluResult;
                zero_d   = i_aluZero;
            end
            RESP: begin
                if (i_rspReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            rsp_id_q     <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            op_q         <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            op_q         <= op_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
        end
    end

    assign o_aluA      = opa_q;
    assign o_aluB      = opb_q;
    assign o_aluOp     = op_q;
    assign o_rspValid  = (state_q == RESP);
    assign o_rspResult = result_q;
    assign o_rspZero   = zero_q;
    assign o_rspId     = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with four requesters: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model and a stand-in ALU.
module tb_alu_arbiter;

    localparam int N    = 4;
    localparam int ID_W = 2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [N-1:0]        req_valid = '0;
    logic [N-1:0][31:0]  req_a = '0;
    logic [N-1:0][31:0]  req_b = '0;
    logic [N-1:0][3:0]   req_op = '0;
    logic [N-1:0]        req_ready;
    logic [31:0]         alu_a, alu_b, alu_res;
    logic [3:0]          alu_op;
    logic                alu_zero;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [31:0]         rsp_result;
    logic                rsp_zero;
    logic [ID_W-1:0]     rsp_id;

    int checks = 0;
    int errors = 0;

    // Reference model state: one in-flight operation and the round-robin pointer.
    bit          m_inflight;
    int          m_age;
    int          m_last;
    logic [31:0] m_a, m_b, m_res;
    logic [3:0]  m_op;
    logic        m_zero;
    int          m_id;

    logic [3:0] ops_tbl [11] = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL,
                                 OP_OR, OP_AND, OP_SUB, OP_SRA, 4'b1111};

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLL:  return a << b[4:0];
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_XOR:  return a ^ b;
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_res  = alu_ref(alu_op, alu_a, alu_b);
    assign alu_zero = (alu_res == 32'd0);

    alu_arbiter #(.NUM_REQ(N), .ID_W(ID_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_reqValid  (req_valid),
        .i_reqA      (req_a),
        .i_reqB      (req_b),
        .i_reqOp     (req_op),
        .o_reqReady  (req_ready),
        .o_aluA      (alu_a),
        .o_aluB      (alu_b),
        .o_aluOp     (alu_op),
        .i_aluResult (alu_res),
        .i_aluZero   (alu_zero),
        .o_rspValid  (rsp_valid),
        .i_rspReady  (rsp_ready),
        .o_rspResult (rsp_result),
        .o_rspZero   (rsp_zero),
        .o_rspId     (rsp_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant();
        if (m_inflight) return -1;
        for (int k = 1; k <= N; k++) begin
            if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    function automatic int obs_grant();
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_inflight = 1'b0;
        m_age      = 0;
        m_last     = N - 1;
        m_a        = '0;
        m_b        = '0;
        m_op       = '0;
        m_res      = '0;
        m_zero     = 1'b0;
        m_id       = 0;
    endtask

    // One clock: compare all outputs with the model, then advance the model at the edge.
    task automatic tick();
        int g;
        #1;
        g = exp_grant();
        chk("ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        chk("rsp_valid", 32'(rsp_valid), 32'(m_inflight && m_age >= 1));
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_op", 32'(alu_op), 32'(m_op));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_zero", 32'(rsp_zero), 32'(m_zero));
        @(posedge clk);
        if (m_inflight) begin
            if (m_age >= 1) begin
                if (rsp_ready) m_inflight = 1'b0;
            end else begin
                m_res  = alu_ref(m_op, m_a, m_b);
                m_zero = (m_res == 32'd0);
                m_age  = 1;
            end
        end else if (g >= 0) begin
            m_inflight = 1'b1;
            m_age      = 0;
            m_a        = req_a[g];
            m_b        = req_b[g];
            m_op       = req_op[g];
            m_id       = g;
            m_last     = g;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_zero", 32'(rsp_zero), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_single(input int idx, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op, input logic [31:0] er, input logic ez);
        bit got = 1'b0;
        req_a[idx]  = a;
        req_b[idx]  = b;
        req_op[idx] = op;
        req_valid   = 4'(1 << idx);
        rsp_ready   = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            #1;
            if (req_ready[idx]) got = 1'b1;
            tick();
            if (got) req_valid = '0;
        end
        chk("single_granted", 32'(got), 32'd1);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            #1;
            if (rsp_valid) begin
                got = 1'b1;
                chk("single_result", rsp_result, er);
                chk("single_zero", 32'(rsp_zero), 32'(ez));
                chk("single_id", 32'(rsp_id), 32'(idx));
            end
            tick();
        end
        chk("single_responded", 32'(got), 32'd1);
    endtask

    initial begin
        int grants[$];
        int g;

        @(negedge clk);
        do_reset();

        // Single request right after reset release: 5 + 7.
        req_a[0] = 32'd5; req_b[0] = 32'd7; req_op[0] = OP_ADD;
        req_valid = 4'b0001; rsp_ready = 1'b1;
        #1 chk("t1_ready_c0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1 chk("t1_alu_a_c1", alu_a, 32'd5);
        chk("t1_alu_b_c1", alu_b, 32'd7);
        chk("t1_rsp_valid_c1", 32'(rsp_valid), 32'd0);
        tick();
        #1 chk("t1_rsp_valid_c2", 32'(rsp_valid), 32'd1);
        chk("t1_result_c2", rsp_result, 32'd12);
        chk("t1_zero_c2", 32'(rsp_zero), 32'd0);
        chk("t1_id_c2", 32'(rsp_id), 32'd0);
        tick();
        tick();

        // Contention between requesters 0 and 1.
        do_reset();
        req_a[0] = 32'd20; req_b[0] = 32'd3; req_op[0] = OP_ADD;
        req_a[1] = 32'd9;  req_b[1] = 32'd9; req_op[1] = OP_SUB;
        req_valid = 4'b0011; rsp_ready = 1'b1;
        grants = {};
        for (int c = 0; c < 40 && grants.size() < 4; c++) begin
            #1;
            g = obs_grant();
            if (g >= 0) grants.push_back(g);
            if (rsp_valid) begin
                if (rsp_id == 2'd0) begin
                    chk("cont_result_id0", rsp_result, 32'd23);
                    chk("cont_zero_id0", 32'(rsp_zero), 32'd0);
                end else begin
                    chk("cont_result_id1", rsp_result, 32'd0);
                    chk("cont_zero_id1", 32'(rsp_zero), 32'd1);
                end
            end
            tick();
        end
        req_valid = '0;
        chk("cont_grant_count", 32'(grants.size()), 32'd4);
        foreach (grants[i]) chk($sformatf("cont_grant_%0d", i), 32'(grants[i]), 32'(i % 2));
        for (int c = 0; c < 4; c++) tick();

        // Back-pressure on the response channel.
        do_reset();
        req_a[2] = 32'd100; req_b[2] = 32'd1; req_op[2] = OP_SUB;
        req_valid = 4'b0100; rsp_ready = 1'b0;
        #1 chk("bp_ready_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0011;
        #1 chk("bp_ready_exec", 32'(req_ready), 32'd0);
        chk("bp_alu_a_exec", alu_a, 32'd100);
        tick();
        for (int c = 0; c < 5; c++) begin
            #1 chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_result", rsp_result, 32'd99);
            chk("bp_id", 32'(rsp_id), 32'd2);
            chk("bp_ready_zero", 32'(req_ready), 32'd0);
            chk("bp_alu_a", alu_a, 32'd100);
            chk("bp_alu_b", alu_b, 32'd1);
            chk("bp_alu_op", 32'(alu_op), 32'(OP_SUB));
            tick();
        end
        rsp_ready = 1'b1;
        #1 chk("bp_hs_valid", 32'(rsp_valid), 32'd1);
        chk("bp_hs_ready", 32'(req_ready), 32'd0);
        tick();
        #1 chk("bp_next_grant", 32'(req_ready), 32'h1);
        chk("bp_next_valid", 32'(rsp_valid), 32'd0);
        tick();
        req_valid = '0;
        for (int c = 0; c < 4; c++) tick();

        // SLT and logic ops through requester 1 alone.
        run_single(1, 32'hFFFF_FFFF, 32'd1, OP_SLT, 32'd1, 1'b0);
        run_single(1, 32'h0000_F0F0, 32'h0000_0FF0, OP_AND, 32'h0000_00F0, 1'b0);
        run_single(1, 32'h1234_5678, 32'h1234_5678, OP_XOR, 32'd0, 1'b1);

        // Reset while requester 1's operation is in EXEC.
        req_a[1] = 32'd40; req_b[1] = 32'd2; req_op[1] = OP_ADD;
        req_valid = 4'b0010; rsp_ready = 1'b1;
        #1 chk("mid_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        #1 chk("mid_exec_alu_a", alu_a, 32'd40);
        do_reset();
        for (int c = 0; c < 4; c++) begin
            #1 chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        req_valid = 4'b0011;
        #1 chk("mid_prio_req0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        for (int c = 0; c < 3; c++) tick();

        // Fairness with all four requesters valid.
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_a[i] = 32'(i * 3 + 1); req_b[i] = 32'(i); req_op[i] = OP_ADD;
        end
        req_valid = 4'b1111; rsp_ready = 1'b1;
        grants = {};
        for (int c = 0; c < 60 && grants.size() < 8; c++) begin
            #1;
            g = obs_grant();
            if (g >= 0) grants.push_back(g);
            tick();
        end
        req_valid = '0;
        chk("fair_grant_count", 32'(grants.size()), 32'd8);
        foreach (grants[i]) chk($sformatf("fair_grant_%0d", i), 32'(grants[i]), 32'(i % N));
        for (int c = 0; c < 4; c++) tick();

        // Random traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                req_a[i]  = $urandom;
                req_b[i]  = ($urandom_range(0, 3) == 0) ? req_a[i] : $urandom;
                req_op[i] = ops_tbl[$urandom_range(0, 10)];
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog timeout");
    end

endmodule
